// File: rtl/visited_pkg.sv
// Shared types and constants for the visited-flag tracker and its RAM core.
package visited_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // On a same-address double write, port B's data is the one stored and returned.
  localparam bit PORT_B_WINS = 1'b1;

  function automatic int depth_f(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/visited_tracker_if.sv
// Bus bundle between the search controller (master) and the visited tracker (slave).
interface visited_tracker_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 5
);
  logic                  clear_start;
  logic                  busy;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic                  we_a;
  logic                  we_b;
  logic [DATA_WIDTH-1:0] q_a;
  logic [DATA_WIDTH-1:0] q_b;
  logic [ADDR_WIDTH:0]   visited_count;
  logic                  all_set;

  modport master (
    output clear_start, data_a, data_b, addr_a, addr_b, we_a, we_b,
    input  busy, q_a, q_b, visited_count, all_set
  );

  modport slave (
    input  clear_start, data_a, data_b, addr_a, addr_b, we_a, we_b,
    output busy, q_a, q_b, visited_count, all_set
  );
endinterface

// File: rtl/dp_ram_wf.sv
// True dual-port write-first RAM core; the array itself carries no reset.
module dp_ram_wf
  import visited_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0] din_a_i,
  output logic [DATA_WIDTH-1:0] dout_a_o,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] din_b_i,
  output logic [DATA_WIDTH-1:0] dout_b_o
);
  localparam int DEPTH = depth_f(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_a_q;
  logic [DATA_WIDTH-1:0] dout_b_q;

  // Port B is written last so it wins a same-address double write.
  always_ff @(posedge clk) begin
    if (we_a_i) mem_q[addr_a_i] <= din_a_i;
    if (we_b_i) mem_q[addr_b_i] <= din_b_i;
    dout_a_q <= we_a_i ? din_a_i : mem_q[addr_a_i];
    dout_b_q <= we_b_i ? din_b_i : mem_q[addr_b_i];
  end

  assign dout_a_o = dout_a_q;
  assign dout_b_o = dout_b_q;

endmodule

// File: rtl/visited_tracker.sv
// Visited-flag store: clear sweep FSM, cross-port forwarding, shadow flags and live set count.
module visited_tracker
  import visited_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 1,
  parameter int                    ADDR_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  visited_tracker_if.slave  bus
);
  localparam int DEPTH = depth_f(ADDR_WIDTH);
  localparam int PTR_W = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam int CW    = ADDR_WIDTH + 2;
  localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(DEPTH / 2 - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic              idle, sweeping, clear_accept, ext_ok;
  logic              same_addr, both_wr, we_a_eff, we_b_eff;
  logic [ADDR_WIDTH-1:0] sweep_addr_a, sweep_addr_b;

  logic                  ram_we_a, ram_we_b;
  logic [ADDR_WIDTH-1:0] ram_addr_a, ram_addr_b;
  logic [DATA_WIDTH-1:0] ram_din_a, ram_din_b, ram_q_a, ram_q_b;

  logic [DEPTH-1:0]      shadow_q, shadow_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  all_set_q, all_set_d;
  logic                  clr_q, clr_d;
  logic                  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [DATA_WIDTH-1:0] fwd_a_data_q, fwd_a_data_d, fwd_b_data_q, fwd_b_data_d;
  logic signed [CW-1:0]  delta_a, delta_b, count_sum;

  assign idle         = (state_q == ST_IDLE);
  assign sweeping     = !idle;
  assign clear_accept = idle && bus.clear_start;
  assign ext_ok       = idle && !bus.clear_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == PTR_LAST) state_d = ST_IDLE;
        else                   ptr_d   = ptr_q + 1'b1;
      end
      ST_IDLE: begin
        if (bus.clear_start) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Sweep clears an even/odd address pair per cycle.
  assign sweep_addr_a = ADDR_WIDTH'({ptr_q, 1'b0});
  assign sweep_addr_b = sweep_addr_a | ADDR_WIDTH'(1);

  assign same_addr = (bus.addr_a == bus.addr_b);
  assign both_wr   = bus.we_a && bus.we_b && same_addr;
  assign we_a_eff  = ext_ok && bus.we_a && !(both_wr && PORT_B_WINS);
  assign we_b_eff  = ext_ok && bus.we_b && !(both_wr && !PORT_B_WINS);

  assign ram_we_a   = sweeping ? 1'b1         : we_a_eff;
  assign ram_we_b   = sweeping ? 1'b1         : we_b_eff;
  assign ram_addr_a = sweeping ? sweep_addr_a : bus.addr_a;
  assign ram_addr_b = sweeping ? sweep_addr_b : bus.addr_b;
  assign ram_din_a  = sweeping ? CLEAR_VALUE  : bus.data_a;
  assign ram_din_b  = sweeping ? CLEAR_VALUE  : bus.data_b;

  dp_ram_wf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .we_a_i   (ram_we_a),
    .addr_a_i (ram_addr_a),
    .din_a_i  (ram_din_a),
    .dout_a_o (ram_q_a),
    .we_b_i   (ram_we_b),
    .addr_b_i (ram_addr_b),
    .din_b_i  (ram_din_b),
    .dout_b_o (ram_q_b)
  );

  // A port that does not write, sharing an address with one that does, returns the written data.
  assign fwd_a_d      = ext_ok && same_addr && we_b_eff && !we_a_eff;
  assign fwd_b_d      = ext_ok && same_addr && we_a_eff && !we_b_eff;
  assign fwd_a_data_d = bus.data_b;
  assign fwd_b_data_d = bus.data_a;
  assign clr_d        = !ext_ok;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shadow
    assign shadow_d[gi] = clear_accept                                        ? 1'b0          :
                          (we_b_eff && bus.addr_b == ADDR_WIDTH'(gi))          ? bus.data_b[0] :
                          (we_a_eff && bus.addr_a == ADDR_WIDTH'(gi))          ? bus.data_a[0] :
                                                                                 shadow_q[gi];
  end

  // Effective writes never share an address, so the two deltas are independent.
  assign delta_a   = we_a_eff ? (CW'(bus.data_a[0]) - CW'(shadow_q[bus.addr_a])) : '0;
  assign delta_b   = we_b_eff ? (CW'(bus.data_b[0]) - CW'(shadow_q[bus.addr_b])) : '0;
  assign count_sum = $signed({1'b0, count_q}) + delta_a + delta_b;
  assign count_d   = clear_accept ? '0 : count_sum[ADDR_WIDTH:0];
  assign all_set_d = (count_d == DEPTH_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= '0;
      count_q      <= '0;
      all_set_q    <= 1'b0;
      clr_q        <= 1'b1;
      fwd_a_q      <= 1'b0;
      fwd_b_q      <= 1'b0;
      fwd_a_data_q <= '0;
      fwd_b_data_q <= '0;
    end else begin
      shadow_q     <= shadow_d;
      count_q      <= count_d;
      all_set_q    <= all_set_d;
      clr_q        <= clr_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      fwd_a_data_q <= fwd_a_data_d;
      fwd_b_data_q <= fwd_b_data_d;
    end
  end

  assign bus.q_a           = clr_q ? CLEAR_VALUE : (fwd_a_q ? fwd_a_data_q : ram_q_a);
  assign bus.q_b           = clr_q ? CLEAR_VALUE : (fwd_b_q ? fwd_b_data_q : ram_q_b);
  assign bus.busy          = sweeping;
  assign bus.visited_count = count_q;
  assign bus.all_set       = all_set_q;

endmodule
